// File: rtl/reg_hazard_scoreboard_pkg.sv
// reg_hazard_scoreboard_pkg: shared ISA opcodes, field macros, bypass encoding and scoreboard entry type.
`ifndef GET_OPC
`define GET_OPC(i) i[31:26]
`define GET_FUN(i) i[5:0]
`define GET_RS(i) i[25:21]
`define GET_RT(i) i[20:16]
`endif
package reg_hazard_scoreboard_pkg;
  localparam int DEPTH = 3;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR = 6'h08, FN_JALR = 6'h09;
  typedef enum logic [1:0] {FWD_REGFILE = 2'd0, FWD_EX = 2'd1, FWD_MEM = 2'd2, FWD_WB = 2'd3} fwd_sel_e;
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } sb_entry_t;
  function automatic logic is_load_op(input logic [5:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction
endpackage

// File: rtl/reg_hazard_scoreboard_decode.sv
// read_reg_decode: which source registers an instruction reads, and whether its opcode is recognised.
module read_reg_decode
  import reg_hazard_scoreboard_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        rs_used_o,
  output logic        rt_used_o,
  output logic        illegal_o
);
  logic [5:0] opc, fun;
  logic unused_bits;
  assign opc = `GET_OPC(instr_i);
  assign fun = `GET_FUN(instr_i);
  assign unused_bits = ^instr_i[25:6];
  always_comb begin
    rs_used_o = 1'b0;
    rt_used_o = 1'b0;
    illegal_o = 1'b0;
    case (opc)
      OP_SPECIAL: begin
        rs_used_o = !(fun inside {FN_SLL, FN_SRL, FN_SRA});
        rt_used_o = !(fun inside {FN_JR, FN_JALR});
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU,
      OP_REGIMM, OP_BGTZ, OP_BLEZ, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: rs_used_o = 1'b1;
      OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
      end
      OP_LUI, OP_J, OP_JAL: ;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard: RAW hazard stall and bypass select for the ID stage over a shift scoreboard of EX/MEM/WB dests.
// Define REG_HAZARD_FWD_EN to enable bypass selects so only load-use hazards stall.
module reg_hazard_scoreboard
  import reg_hazard_scoreboard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [4:0]  id_write_reg,
  input  logic        flush,
  output logic        stall,
  output logic        rs_used,
  output logic        rt_used,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic        illegal
);
  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [4:0] rs, rt;
  logic [DEPTH-1:0] rs_hit, rt_hit;
  logic dec_illegal, hazard, issue, unused_ld;
  read_reg_decode u_dec (
    .instr_i  (id_instr),
    .rs_used_o(rs_used),
    .rt_used_o(rt_used),
    .illegal_o(dec_illegal)
  );
  assign rs = `GET_RS(id_instr);
  assign rt = `GET_RT(id_instr);
  // Only entries already in flight are compared, so an instruction never matches its own dest.
  always_comb begin
    rs_hit = '0;
    rt_hit = '0;
    unused_ld = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      rs_hit[k] = rs_used && rs != 5'd0 && sb_q[k].valid && sb_q[k].dest == rs;
      rt_hit[k] = rt_used && rt != 5'd0 && sb_q[k].valid && sb_q[k].dest == rt;
      unused_ld ^= sb_q[k].is_load;
    end
  end
  function automatic logic [1:0] youngest(input logic [DEPTH-1:0] hit);
    youngest = FWD_REGFILE;
    for (int k = DEPTH - 1; k >= 0; k--) if (hit[k]) youngest = 2'(k + 1);
  endfunction
`ifdef REG_HAZARD_FWD_EN
  assign hazard = (rs_hit[0] || rt_hit[0]) && sb_q[0].is_load;
  assign fwd_rs_sel = youngest(rs_hit);
  assign fwd_rt_sel = youngest(rt_hit);
`else
  assign hazard = |{rs_hit, rt_hit};
  assign fwd_rs_sel = FWD_REGFILE;
  assign fwd_rt_sel = FWD_REGFILE;
`endif
  assign stall = id_valid && !flush && hazard;
  assign illegal = id_valid && dec_illegal;
  assign issue = id_valid && !stall && !flush;
  always_comb begin
    sb_d[0] = issue ? sb_entry_t'{1'b1, id_write_reg, is_load_op(`GET_OPC(id_instr))} : '0;
    sb_d[DEPTH-1:1] = sb_q[DEPTH-2:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sb_q <= '0;
    else sb_q <= sb_d;
endmodule

// File: doc/reg_hazard_scoreboard.md
# reg_hazard_scoreboard

Read-side counterpart to the destination-register decode: determines which source registers (rs, rt) the instruction in ID reads, and tracks the destination registers of in-flight instructions in a short shift scoreboard. From these it raises a pipeline stall on read-after-write hazards and, when forwarding is compiled in, selects bypass sources. Sits beside the ID stage of the 5-stage pipeline and is driven by the per-instruction destination register already produced for ID.

## Interface
- DEPTH, 3: tracked in-flight stages; entry 0 = EX, 1 = MEM, 2 = WB. The register file is not write-through, so WB counts as a hazard.
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_instr  input  32  instruction in ID.
- id_write_reg  input  5  destination register of the ID instruction; 0 = none.
- flush  input  1  synchronous kill of the ID instruction (branch/jump redirect).
- stall  output  1  hold PC/IF/ID; a bubble is inserted into EX.
- rs_used  output  1  ID instruction reads rs.
- rt_used  output  1  ID instruction reads rt.
- fwd_rs_sel  output  2  rs bypass: 0 = regfile, 1 = EX, 2 = MEM, 3 = WB.
- fwd_rt_sel  output  2  rt bypass, same encoding.
- illegal  output  1  opcode/funct not recognised while id_valid.

## Operation
- Source decode (combinational):
  - SPECIAL, SLL/SRL/SRA: rt only.
  - SPECIAL, JR/JALR: rs only.
  - SPECIAL, other: rs and rt.
  - ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU: rs only.
  - LUI, J, JAL: none.
  - REGIMM, BGTZ, BLEZ: rs only.
  - BEQ, BNE: rs and rt.
  - Loads: rs only.
  - Stores: rs and rt.
  - Unrecognised opcode: none, and illegal=1.
- Register 0 never hazards; a source of 0 is treated as unused for matching.
- Scoreboard entry i holds {valid, dest[4:0], is_load}. Each cycle all entries shift: i → i+1, and entry DEPTH-1 retires.
- Entry 0 loads {1, id_write_reg, opcode∈{LB,LBU,LH,LHU,LW}} when id_valid && !stall && !flush. Otherwise entry 0 loads a bubble {0, 0, 0}.
- Match(i, r): entry i valid, dest==r, r≠0.
- Without forwarding:
  - stall = id_valid && !flush && any used source matches any entry.
  - fwd_*_sel = 0.
- With forwarding (see Configuration):
  - stall only on a load-use hazard: a used source matches entry 0 and that entry has is_load=1.
  - Otherwise fwd_*_sel selects the youngest matching entry (lowest i), encoded as i+1.
- flush overrides stall: stall=0, and a bubble is inserted.

## Timing
- Decode, stall, fwd, used and illegal outputs are combinational from id_instr and the registered scoreboard; there are no other registered outputs.
- Reset (async assert, sync release): all entries invalid. stall=0 whenever id_valid=0; fwd_*_sel=0.
- Stall latency: the hazard is visible in the same cycle the consumer sits in ID. Without forwarding, a back-to-back dependency stalls exactly DEPTH cycles. With forwarding, a load-use dependency stalls exactly 1 cycle.
- Reset asserted mid-stall clears all entries immediately; stall drops in the same cycle.
- An instruction that reads and writes the same register (e.g. addi $5,$5,1) matches only older entries, never itself.

## Configuration
- REG_HAZARD_FWD_EN defined: bypass selects are active and only load-use hazards stall.
- REG_HAZARD_FWD_EN undefined: no bypass; fwd_rs_sel/fwd_rt_sel are tied to 0 and every RAW hazard stalls until the producer retires.
- The is_load bit exists in both builds.

## Structure
- Opcode/funct/REGIMM constants and the GET_OPC/GET_FUN/GET_RS/GET_RT field macros come from the shared ISA header; no new constants are defined locally.
- Add a FWD_* select encoding (REGFILE/EX/MEM/WB) to the shared header so the datapath muxes use the same values.
- Source decode is one combinational sub-module, read_reg_decode (instruction → rs_used, rt_used, illegal).
- The scoreboard and hazard compare live in the top module.

## Test plan
- Without FWD: addi $8,$0,1, then add $9,$8,$8 → stall=1 for 3 cycles, $9's add issues on cycle 4; fwd=0.
- With FWD: same pair → stall=0 and fwd_rs_sel=fwd_rt_sel=1. With one independent instruction between them → sel=2.
- With FWD: lw $4,0($2), then sw $4,4($3) → stall=1 for exactly 1 cycle, then fwd_rt_sel=2, fwd_rs_sel=0.
- Writer addu $0,$1,$2, then reader sll $3,$0,2 → no stall; rs_used=0, rt_used=1. Reader lui $6,1 → no stall, rs_used=rt_used=0.
- Hazard pending, flush=1 in the same cycle → stall=0 and entry 0 becomes a bubble; a later reader of the flushed dest does not stall.
- rst_n pulsed low while stall=1 → stall=0 asynchronously and the scoreboard is empty. Opcode 6'b111111 with id_valid → illegal=1, stall=0.
